window_register: RTL and testbench

- Parametrised successor of the single enabled register: a DEPTH-entry, WIDTH-bit sliding-window register bank for vital-sign samples.
- Every enabled load shifts in one sample. The block tracks fill count and keeps a running sum, and provides a moving average once the window is full.
- Sits between the sensor sampling logic and the alarm/threshold comparators. Replaces ad-hoc chains of single registers.

---
 rtl/window_register.sv | 94 +++++++++
 tb/tb_window_register.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/window_register.sv
// -----------------------------------------------------------------------------
// window_register
//
// Sliding-window register bank for vital-sign samples. Each enabled load
// shifts one sample into a DEPTH-entry chain. The block keeps a running sum
// and a fill count, and exposes a truncating moving average (sum / DEPTH).
// It sits between the sensor sampling logic and the alarm/threshold
// comparators.
//
// Parameters
//   WIDTH      sample width in bits (unsigned)
//   DEPTH      window length in samples; power of two, 2..256
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (asserted when 0)
//   en         load strobe: data_in is shifted in on this edge
//   clr        synchronous flush of the window; takes priority over en
//   data_in    new sample
//   newest_out most recently loaded sample (entry 0)
//   oldest_out entry DEPTH-1, which the next load evicts; 0 until full
//   sum_out    sum of all DEPTH entries
//   avg_out    sum_out >> log2(DEPTH); only meaningful while full = 1
//   count      number of valid entries, saturating at DEPTH
//   full       count == DEPTH
//
// Every output is taken from registered state, so there is no combinational
// path from any input to any output. A load on edge N is visible after N.
// -----------------------------------------------------------------------------
module window_register #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              clr,
  input  logic [WIDTH-1:0]                  data_in,
  output logic [WIDTH-1:0]                  newest_out,
  output logic [WIDTH-1:0]                  oldest_out,
  output logic [WIDTH+$clog2(DEPTH)-1:0]    sum_out,
  output logic [WIDTH-1:0]                  avg_out,
  output logic [$clog2(DEPTH):0]            count,
  output logic                              full
);

  localparam int LOG2_D = $clog2(DEPTH);
  localparam int SUM_W  = WIDTH + LOG2_D;
  localparam int CNT_W  = LOG2_D + 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_entries [DEPTH];
  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_count;

  logic [SUM_W-1:0] w_sum_next;

  // Entries that have not been loaded yet are always 0, so subtracting the
  // evicted entry keeps the sum exact with no overflow or underflow at SUM_W.
  assign w_sum_next = r_sum + SUM_W'(data_in) - SUM_W'(r_entries[DEPTH-1]);

  // NOTE: The sample storage sits inside the async reset on purpose: the
  // window must read back as all zeros immediately on reset, and oldest_out
  // and the running sum both depend on every entry being cleared.
  // NOTE: Sequential state uses non-blocking assignments so every entry of the
  // shift chain samples its neighbour's pre-edge value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
      r_sum   <= '0;
      r_count <= '0;
    end else if (clr) begin
      // Flush wins over a simultaneous load; data_in is discarded.
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
      r_sum   <= '0;
      r_count <= '0;
    end else if (en) begin
      r_entries[0] <= data_in;
      for (int i = 1; i < DEPTH; i++) r_entries[i] <= r_entries[i-1];
      r_sum <= w_sum_next;
      if (r_count != FULL_CNT) r_count <= r_count + 1'b1;
    end
  end

  assign newest_out = r_entries[0];
  assign oldest_out = r_entries[DEPTH-1];
  assign sum_out    = r_sum;
  // The upper WIDTH bits of the sum are exactly sum >> LOG2_D.
  assign avg_out    = r_sum[SUM_W-1:LOG2_D];
  assign count      = r_count;
  assign full       = (r_count == FULL_CNT);

endmodule

// File: tb/tb_window_register.sv
// -----------------------------------------------------------------------------
// tb_window_register
//
// Directed bench for window_register. A DEPTH=4/WIDTH=8 instance is driven
// from a table of {inputs, expected outputs} records; reset, asynchronous
// reset mid-window and a DEPTH=2/WIDTH=16 instance use hand-written sequences.
// -----------------------------------------------------------------------------
module tb_window_register;

  logic clk;
  logic rst;

  // DEPTH=4, WIDTH=8 instance
  logic       en4, clr4;
  logic [7:0] din4;
  logic [7:0] newest4, oldest4, avg4;
  logic [9:0] sum4;
  logic [2:0] cnt4;
  logic       full4;

  // DEPTH=2, WIDTH=16 instance
  logic        en2, clr2;
  logic [15:0] din2;
  logic [15:0] newest2, oldest2, avg2;
  logic [16:0] sum2;
  logic [1:0]  cnt2;
  logic        full2;

  int n_checks = 0;
  int n_fail   = 0;

  window_register #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .en         (en4),
    .clr        (clr4),
    .data_in    (din4),
    .newest_out (newest4),
    .oldest_out (oldest4),
    .sum_out    (sum4),
    .avg_out    (avg4),
    .count      (cnt4),
    .full       (full4)
  );

  window_register #(.WIDTH(16), .DEPTH(2)) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .en         (en2),
    .clr        (clr2),
    .data_in    (din2),
    .newest_out (newest2),
    .oldest_out (oldest2),
    .sum_out    (sum2),
    .avg_out    (avg2),
    .count      (cnt2),
    .full       (full2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       clr;
    logic [7:0] din;
    logic [7:0] newest;
    logic [7:0] oldest;
    logic [9:0] sum;
    logic [7:0] avg;
    logic [2:0] cnt;
    logic       full;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic e, logic c, logic [7:0] d, logic [7:0] n,
                              logic [7:0] o, logic [9:0] s, logic [7:0] a,
                              logic [2:0] k, logic f);
    vec_t v;
    v.en = e; v.clr = c; v.din = d; v.newest = n; v.oldest = o;
    v.sum = s; v.avg = a; v.cnt = k; v.full = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [7:0] n, input logic [7:0] o,
                        input logic [9:0] s, input logic [7:0] a,
                        input logic [2:0] k, input logic f);
    check({tag, " newest"}, 32'(newest4), 32'(n));
    check({tag, " oldest"}, 32'(oldest4), 32'(o));
    check({tag, " sum"},    32'(sum4),    32'(s));
    check({tag, " avg"},    32'(avg4),    32'(a));
    check({tag, " count"},  32'(cnt4),    32'(k));
    check({tag, " full"},   32'(full4),   32'(f));
  endtask

  task automatic load4(input logic [7:0] d);
    @(negedge clk);
    en4 = 1'b1; clr4 = 1'b0; din4 = d;
    @(negedge clk);
    en4 = 1'b0;
  endtask

  initial begin
    rst  = 1'b0;
    en4  = 1'b0; clr4 = 1'b0; din4 = '0;
    en2  = 1'b0; clr2 = 1'b0; din2 = '0;

    // ---- reset held for 3 cycles, then idle for 5 -------------------------
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check4($sformatf("reset[%0d]", i), 0, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check4($sformatf("idle[%0d]", i), 0, 0, 0, 0, 0, 0);
    end

    // ---- table-driven sequence -------------------------------------------
    //              en clr din  newest oldest sum  avg cnt full
    // fill
    vecs.push_back(mk(1, 0,  10,  10,   0,   10,   2, 1, 0));
    vecs.push_back(mk(1, 0,  20,  20,   0,   30,   7, 2, 0));
    vecs.push_back(mk(1, 0,  30,  30,   0,   60,  15, 3, 0));
    vecs.push_back(mk(1, 0,  40,  40,  10,  100,  25, 4, 1));
    // wrap / evict
    vecs.push_back(mk(1, 0, 200, 200,  20,  290,  72, 4, 1));
    vecs.push_back(mk(1, 0, 255, 255,  30,  525, 131, 4, 1));
    // idle while full holds
    vecs.push_back(mk(0, 0,  77, 255,  30,  525, 131, 4, 1));
    // flush, then gaps
    vecs.push_back(mk(0, 1,   0,   0,   0,    0,   0, 0, 0));
    vecs.push_back(mk(1, 0,   5,   5,   0,    5,   1, 1, 0));
    vecs.push_back(mk(0, 0,  77,   5,   0,    5,   1, 1, 0));
    vecs.push_back(mk(0, 0,  88,   5,   0,    5,   1, 1, 0));
    vecs.push_back(mk(1, 0,   7,   7,   0,   12,   3, 2, 0));
    // clr priority over en
    vecs.push_back(mk(1, 1,  99,   0,   0,    0,   0, 0, 0));
    vecs.push_back(mk(1, 0, 255, 255,   0,  255,  63, 1, 0));
    vecs.push_back(mk(1, 0, 255, 255,   0,  510, 127, 2, 0));
    vecs.push_back(mk(1, 0, 255, 255,   0,  765, 191, 3, 0));
    vecs.push_back(mk(1, 0, 255, 255, 255, 1020, 255, 4, 1));
    vecs.push_back(mk(1, 1,  99,   0,   0,    0,   0, 0, 0));
    vecs.push_back(mk(1, 0,  99,  99,   0,   99,  24, 1, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      en4 = vecs[i].en; clr4 = vecs[i].clr; din4 = vecs[i].din;
      @(posedge clk); #1;
      check4($sformatf("vec[%0d]", i), vecs[i].newest, vecs[i].oldest,
             vecs[i].sum, vecs[i].avg, vecs[i].cnt, vecs[i].full);
    end
    @(negedge clk);
    en4 = 1'b0; clr4 = 1'b0;

    // ---- async reset mid-window ------------------------------------------
    // Window currently 99; loading 1,2,3 fills it: {3,2,1,99}, sum 105.
    load4(8'd1);
    load4(8'd2);
    load4(8'd3);
    check4("prefill", 3, 99, 105, 26, 4, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check4("async_rst", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check4("rst_held", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    load4(8'd3);
    check4("post_rst_load", 3, 0, 3, 0, 1, 0);

    // ---- DEPTH=2, WIDTH=16 -----------------------------------------------
    @(negedge clk);
    en2 = 1'b1; din2 = 16'hFFFF;
    @(posedge clk); #1;
    check("d2 first sum",   32'(sum2),  32'd65535);
    check("d2 first full",  32'(full2), 32'd0);
    @(negedge clk);
    din2 = 16'hFFFF;
    @(posedge clk); #1;
    check("d2 sum",    32'(sum2),    32'd131070);
    check("d2 avg",    32'(avg2),    32'd65535);
    check("d2 count",  32'(cnt2),    32'd2);
    check("d2 full",   32'(full2),   32'd1);
    check("d2 oldest", 32'(oldest2), 32'd65535);
    @(negedge clk);
    din2 = 16'd1;
    @(posedge clk); #1;
    check("d2 evict sum",    32'(sum2),    32'd65536);
    check("d2 evict avg",    32'(avg2),    32'd32768);
    check("d2 evict newest", 32'(newest2), 32'd1);
    check("d2 evict oldest", 32'(oldest2), 32'd65535);
    check("d2 evict count",  32'(cnt2),    32'd2);
    @(negedge clk);
    en2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
